// File: rtl/ps2_key_fifo.sv
// PS/2 keyboard front end: conditions the raw clock and data lines, receives frames,
// decodes scancodes (with shift) to ASCII and queues the characters in a FWFT FIFO.
module ps2_key_fifo #(
  parameter int DEPTH      = 16,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     frame_err,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  logic          clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
  logic          filt_q, filt_d, filt_prev_q, filt_prev_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          strobe_q, strobe_d;

  logic [1:0]    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    sr_q, sr_d;
  logic          par_ok_q, par_ok_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          frame_err_q, frame_err_d;
  logic          rx_valid;

  logic          ext_q, ext_d, brk_q, brk_d, shift_q, shift_d;
  logic          dec_valid_q, dec_valid_d;
  logic [7:0]    dec_char_q, dec_char_d;
  logic [8:0]    mapped;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          pop, wr_en;

  function automatic logic [5:0] letter_idx(input logic [7:0] code);
    case (code)
      8'h1C: letter_idx = {1'b1, 5'd0};   8'h32: letter_idx = {1'b1, 5'd1};
      8'h21: letter_idx = {1'b1, 5'd2};   8'h23: letter_idx = {1'b1, 5'd3};
      8'h24: letter_idx = {1'b1, 5'd4};   8'h2B: letter_idx = {1'b1, 5'd5};
      8'h34: letter_idx = {1'b1, 5'd6};   8'h33: letter_idx = {1'b1, 5'd7};
      8'h43: letter_idx = {1'b1, 5'd8};   8'h3B: letter_idx = {1'b1, 5'd9};
      8'h42: letter_idx = {1'b1, 5'd10};  8'h4B: letter_idx = {1'b1, 5'd11};
      8'h3A: letter_idx = {1'b1, 5'd12};  8'h31: letter_idx = {1'b1, 5'd13};
      8'h44: letter_idx = {1'b1, 5'd14};  8'h4D: letter_idx = {1'b1, 5'd15};
      8'h15: letter_idx = {1'b1, 5'd16};  8'h2D: letter_idx = {1'b1, 5'd17};
      8'h1B: letter_idx = {1'b1, 5'd18};  8'h2C: letter_idx = {1'b1, 5'd19};
      8'h3C: letter_idx = {1'b1, 5'd20};  8'h2A: letter_idx = {1'b1, 5'd21};
      8'h1D: letter_idx = {1'b1, 5'd22};  8'h22: letter_idx = {1'b1, 5'd23};
      8'h35: letter_idx = {1'b1, 5'd24};  8'h1A: letter_idx = {1'b1, 5'd25};
      default: letter_idx = 6'd0;
    endcase
  endfunction

  // Result is {hit, ascii}; hit=0 means the code has no printable mapping.
  function automatic logic [8:0] map_code(input logic [7:0] code, input logic sh);
    logic [5:0] li;
    li = letter_idx(code);
    map_code = 9'h000;
    if (li[5]) begin
      map_code = {1'b1, (sh ? 8'h41 : 8'h61) + {3'b000, li[4:0]}};
    end else begin
      case (code)
        8'h45: map_code = {1'b1, 8'h30};
        8'h16: map_code = {1'b1, 8'h31};
        8'h1E: map_code = {1'b1, 8'h32};
        8'h26: map_code = {1'b1, 8'h33};
        8'h25: map_code = {1'b1, 8'h34};
        8'h2E: map_code = {1'b1, 8'h35};
        8'h36: map_code = {1'b1, 8'h36};
        8'h3D: map_code = {1'b1, 8'h37};
        8'h3E: map_code = {1'b1, sh ? 8'h2A : 8'h38};
        8'h46: map_code = {1'b1, 8'h39};
        8'h29: map_code = {1'b1, 8'h20};
        8'h5A: map_code = {1'b1, 8'h0D};
        8'h66: map_code = {1'b1, 8'h08};
        8'h4E: map_code = {1'b1, 8'h2D};
        8'h55: map_code = {1'b1, sh ? 8'h2B : 8'h3D};
        default: map_code = 9'h000;
      endcase
    end
  endfunction

  // Glitch filter plus registered falling-edge detect gives the per-bit sample strobe.
  always_comb begin
    filt_d      = filt_q;
    filt_cnt_d  = '0;
    if (clk_sync_q != filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
    filt_prev_d = filt_q;
    strobe_d    = filt_prev_q & ~filt_q;
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sr_d        = sr_q;
    par_ok_d    = par_ok_q;
    frame_err_d = 1'b0;
    rx_valid    = 1'b0;
    if (state_q == ST_IDLE || strobe_q) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
    if (strobe_q) begin
      case (state_q)
        ST_IDLE: begin
          if (!data_sync_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        ST_DATA: begin
          sr_d      = {data_sync_q, sr_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_ok_d = ^{sr_q, data_sync_q};
          state_d  = ST_STOP;
        end
        default: begin
          if (data_sync_q && par_ok_q) rx_valid = 1'b1;
          else frame_err_d = 1'b1;
          state_d = ST_IDLE;
        end
      endcase
    end else if (state_q != ST_IDLE && to_cnt_q == TW'(TIMEOUT)) begin
      state_d = ST_IDLE;
    end
  end

  // Break and extended prefixes only modify flags; shift keys never push a character.
  always_comb begin
    ext_d       = ext_q;
    brk_d       = brk_q;
    shift_d     = shift_q;
    dec_valid_d = 1'b0;
    dec_char_d  = 8'h00;
    mapped      = map_code(sr_q, shift_q);
    if (rx_valid) begin
      if (sr_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (sr_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (brk_q) begin
        if ((sr_q == 8'h12 || sr_q == 8'h59) && !ext_q) shift_d = 1'b0;
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else if (ext_q) begin
        ext_d = 1'b0;
      end else if (sr_q == 8'h12 || sr_q == 8'h59) begin
        shift_d = 1'b1;
      end else begin
        dec_valid_d = mapped[8];
        dec_char_d  = mapped[7:0];
      end
    end
  end

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == (AW+1)'(DEPTH));
    pop      = rd_en && !empty;
    wr_en    = dec_valid_q && (!full || pop);
    overflow = dec_valid_q && full && !pop;
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    rd_data  = empty ? 8'h00 : mem_q[rd_ptr_q];
    count    = count_q;
    frame_err = frame_err_q;
  end

  // Line synchronizers and filter reset to the PS/2 idle-high level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      filt_cnt_q  <= '0;
      strobe_q    <= 1'b0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      sr_q        <= 8'h00;
      par_ok_q    <= 1'b0;
      to_cnt_q    <= '0;
      frame_err_q <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      shift_q     <= 1'b0;
      dec_valid_q <= 1'b0;
      dec_char_q  <= 8'h00;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
      filt_q      <= filt_d;
      filt_prev_q <= filt_prev_d;
      filt_cnt_q  <= filt_cnt_d;
      strobe_q    <= strobe_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      par_ok_q    <= par_ok_d;
      to_cnt_q    <= to_cnt_d;
      frame_err_q <= frame_err_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      shift_q     <= shift_d;
      dec_valid_q <= dec_valid_d;
      dec_char_q  <= dec_char_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= dec_char_q;
  end

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Randomized self-checking bench for ps2_key_fifo: drives PS/2 frames bit by bit and
// compares FIFO state and error pulses against a scancode/queue reference model.
module tb_ps2_key_fifo;

  localparam int DEPTH      = 16;
  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 1000;
  localparam int HALF       = 16;

  logic       clk = 1'b0;
  logic       rst_n, ps2_clk, ps2_data, rd_en;
  logic [7:0] rd_data;
  logic       empty, full, frame_err, overflow;
  logic [4:0] count;

  int checks = 0;
  int errors = 0;
  int ferrHigh = 0, ovfHigh = 0, expFrameErr = 0, expOverflow = 0;

  logic [7:0] expQ [$];
  bit extF, brkF, shiftF;

  logic [7:0] letterCodes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                   8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                   8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                   8'h35, 8'h1A};
  logic [7:0] digitCodes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                  8'h3E, 8'h46};
  logic [7:0] symbolCodes [5] = '{8'h29, 8'h5A, 8'h66, 8'h4E, 8'h55};
  logic [7:0] junkCodes [5]   = '{8'h76, 8'h0E, 8'h05, 8'h14, 8'h11};

  ps2_key_fifo #(.DEPTH(DEPTH), .FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .full(full), .count(count),
    .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) ferrHigh++;
    if (overflow) ovfHigh++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int asciiOf(input logic [7:0] b, input bit sh);
    for (int i = 0; i < 26; i++) if (b == letterCodes[i]) return sh ? 65 + i : 97 + i;
    for (int i = 0; i < 10; i++) if (b == digitCodes[i]) return (sh && i == 8) ? 42 : 48 + i;
    case (b)
      8'h29: return 32;
      8'h5A: return 13;
      8'h66: return 8;
      8'h4E: return 45;
      8'h55: return sh ? 43 : 61;
      default: return -1;
    endcase
  endfunction

  task automatic modelFrame(input logic [7:0] b, input bit bad);
    int a;
    if (bad) begin
      expFrameErr++;
    end else if (b == 8'hE0) begin
      extF = 1;
    end else if (b == 8'hF0) begin
      brkF = 1;
    end else if (brkF) begin
      if ((b == 8'h12 || b == 8'h59) && !extF) shiftF = 0;
      brkF = 0;
      extF = 0;
    end else if (extF) begin
      extF = 0;
    end else if (b == 8'h12 || b == 8'h59) begin
      shiftF = 1;
    end else begin
      a = asciiOf(b, shiftF);
      if (a >= 0) begin
        if (expQ.size() == DEPTH) expOverflow++;
        else expQ.push_back(8'(a));
      end
    end
  endtask

  task automatic sendBit(input bit b);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] code, input bit badParity, input bit badStop);
    bit par;
    par = ~^code;
    if (badParity) par = ~par;
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(code[i]);
    sendBit(par);
    sendBit(!badStop);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    modelFrame(code, badParity || badStop);
  endtask

  // Stop bit handled here so the cycle offsets after its falling edge can be checked.
  task automatic timedFrame(input logic [7:0] code, input bit badParity);
    bit par;
    par = ~^code;
    if (badParity) par = ~par;
    modelFrame(code, badParity);
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(code[i]);
    sendBit(par);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (11) @(negedge clk);
    checkOutput("t11_frame_err", frame_err, 0);
    @(negedge clk);
    checkOutput("t12_frame_err", frame_err, badParity);
    checkOutput("t12_empty", empty, 1);
    @(negedge clk);
    checkOutput("t13_frame_err", frame_err, 0);
    checkOutput("t13_empty", empty, expQ.size() == 0);
    checkOutput("t13_count", count, expQ.size());
    repeat (HALF - 13) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, ":count"}, count, expQ.size());
    checkOutput({tag, ":empty"}, empty, expQ.size() == 0);
    checkOutput({tag, ":full"}, full, expQ.size() == DEPTH);
    checkOutput({tag, ":rd_data"}, rd_data, expQ.size() > 0 ? 32'(expQ[0]) : 32'h0);
    checkOutput({tag, ":frame_err_cycles"}, ferrHigh, expFrameErr);
    checkOutput({tag, ":overflow_cycles"}, ovfHigh, expOverflow);
  endtask

  task automatic popOne();
    if (expQ.size() > 0) checkOutput("pop_data", rd_data, expQ[0]);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if (expQ.size() > 0) void'(expQ.pop_front());
  endtask

  initial begin
    int r, n;
    logic [7:0] code;
    bit bp, bs;
    rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0;
    repeat (3) @(negedge clk);
    checkState("reset");
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    timedFrame(8'h1C, 1'b0);
    checkOutput("first_char", rd_data, 8'h61);
    checkState("frame_1c");
    popOne();
    checkState("after_pop");

    timedFrame(8'h1C, 1'b1);
    checkState("bad_parity");
    applyStimulus(8'h45, 0, 0);
    checkOutput("digit_zero", rd_data, 8'h30);
    popOne();

    foreach (expQ[i]) expQ.delete(i);
    applyStimulus(8'h12, 0, 0); applyStimulus(8'h1C, 0, 0);
    applyStimulus(8'hF0, 0, 0); applyStimulus(8'h1C, 0, 0);
    applyStimulus(8'hF0, 0, 0); applyStimulus(8'h12, 0, 0);
    applyStimulus(8'h1C, 0, 0);
    checkState("shift_seq");
    checkOutput("shift_upper", rd_data, 8'h41);
    popOne();
    checkOutput("shift_lower", rd_data, 8'h61);
    popOne();
    checkState("shift_drained");

    for (int i = 0; i < 17; i++) begin
      applyStimulus(8'h16, 0, 0);
      if (i == 15) checkOutput("full_at_16", full, 1);
    end
    checkState("overflow");
    checkOutput("count_held", count, 16);
    for (int i = 0; i < 16; i++) begin
      checkOutput("burst_pop", rd_data, 8'h31);
      popOne();
    end
    checkState("burst_drained");

    sendBit(1'b0);
    sendBit(1'b1); sendBit(1'b0); sendBit(1'b1); sendBit(1'b1);
    ps2_data = 1'b1;
    repeat (TIMEOUT + 10) @(negedge clk);
    applyStimulus(8'h29, 0, 0);
    checkOutput("timeout_space", rd_data, 8'h20);
    checkState("timeout");
    popOne();

    applyStimulus(8'h1C, 0, 0); applyStimulus(8'h32, 0, 0); applyStimulus(8'h21, 0, 0);
    sendBit(1'b0);
    for (int i = 0; i < 5; i++) sendBit(i[0]);
    ps2_data = 1'b1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_rd_data", rd_data, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_frame_err", frame_err, 0);
    checkOutput("rst_overflow", overflow, 0);
    while (expQ.size() > 0) void'(expQ.pop_front());
    extF = 0; brkF = 0; shiftF = 0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    applyStimulus(8'h5A, 0, 0);
    checkOutput("post_reset_cr", rd_data, 8'h0D);
    checkState("post_reset");
    popOne();

    for (int it = 0; it < 50; it++) begin
      r = $urandom_range(0, 99);
      if (r < 10)      code = ($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59;
      else if (r < 18) code = 8'hF0;
      else if (r < 23) code = 8'hE0;
      else if (r < 30) code = junkCodes[$urandom_range(0, 4)];
      else if (r < 70) code = letterCodes[$urandom_range(0, 25)];
      else if (r < 85) code = digitCodes[$urandom_range(0, 9)];
      else             code = symbolCodes[$urandom_range(0, 4)];
      bp = ($urandom_range(0, 11) == 0);
      bs = !bp && ($urandom_range(0, 15) == 0);
      applyStimulus(code, bp, bs);
      checkState("rnd_frame");
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) popOne();
      checkState("rnd_pop");
    end

    while (expQ.size() > 0) popOne();
    checkState("final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_fifo.md
# ps2_key_fifo

Upstream input stage for the terminal path. It receives raw PS/2 keyboard frames and decodes make/break scancodes, including shift state, into ASCII. Decoded characters are queued in a first-word-fall-through FIFO. The keyboard buffer and state machine inside the internal processing block pop characters with a one-cycle read strobe.

## Interface
- DEPTH, 16, FIFO entries; power of two.
- FILTER_LEN, 8, consecutive clk cycles the synchronized ps2_clk must hold a level before the filtered clock changes.
- TIMEOUT, 50000, clk cycles without a filtered falling edge mid-frame before the frame is abandoned (500 us at 100 MHz).
- clk, in, 1, system clock; all state on rising edge.
- rst_n, in, 1, asynchronous active-low reset; clears all state.
- ps2_clk, in, 1, raw keyboard clock; asynchronous.
- ps2_data, in, 1, raw keyboard data; asynchronous.
- rd_en, in, 1, pop strobe; ignored while empty.
- rd_data, out, 8, ASCII at FIFO head; valid while empty=0; 8'h00 while empty.
- empty, out, 1, FIFO holds 0 entries.
- full, out, 1, FIFO holds DEPTH entries.
- count, out, $clog2(DEPTH)+1, occupancy.
- frame_err, out, 1, one-cycle pulse on parity or stop-bit failure.
- overflow, out, 1, one-cycle pulse when a decoded character is dropped because the FIFO is full.

## Operation
- **Input conditioning**
  - ps2_clk and ps2_data each pass through a 2-FF synchronizer.
  - The filtered clock changes level only after FILTER_LEN consecutive identical synchronized samples.
  - A filtered falling edge produces one sample-strobe cycle.
- **Frame receiver**
  - States: IDLE, DATA, PARITY, STOP.
  - IDLE: on a strobe with data=0 (start bit), go to DATA. A start bit of 1 is ignored and the receiver stays in IDLE.
  - DATA: shift in 8 bits, LSB first, then go to PARITY.
  - PARITY: sample the bit; the 9 bits (8 data + parity) must contain an odd number of ones. Go to STOP.
  - STOP: sample the bit. If the stop bit is 1 and parity is good, present the byte to the decoder. Otherwise pulse frame_err and discard the byte. Return to IDLE.
  - A timeout counter clears on every strobe. If it reaches TIMEOUT in any non-IDLE state, return to IDLE silently, with no frame_err.
- **Decoder** (flags: ext, brk, shift; all reset to 0)
  - E0: set ext.
  - F0: set brk.
  - Any other byte with brk=1: if the byte is 12 or 59 and ext=0, clear shift. Nothing is pushed. Clear brk and ext.
  - Any other byte with brk=0, ext=1: dropped. Clear ext.
  - Make codes 12 and 59 set shift.
  - Letters: 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A map to a..z (0x61..0x7A). With shift set they map to 0x41..0x5A.
  - Digits: 45 16 1E 26 25 2E 36 3D 3E 46 map to 0..9 (0x30..0x39).
  - Symbols: 29 → 0x20, 5A → 0x0D, 66 → 0x08, 4E → 0x2D, 55 → 0x3D (shift: 0x2B), 3E with shift → 0x2A.
  - Unmapped codes are dropped.
  - Typematic repeats are pushed each time.
- **FIFO**
  - Push occurs when a decoded character is valid. Pop occurs when rd_en=1 and empty=0.
  - Pointers wrap modulo DEPTH.
  - Push while full without a simultaneous pop: the character is dropped, overflow pulses, and contents are unchanged.
  - Push and pop in the same cycle while full: both succeed and count is unchanged.
  - Push and pop in the same cycle while empty: only the push takes effect.

## Timing
- **Reset values:** rd_data=8'h00, empty=1, full=0, count=0, frame_err=0, overflow=0. Receiver is in IDLE and all flags are clear.
- **Reset mid-frame:** the partial frame is discarded. The next start bit after release begins a fresh frame.
- **Edge detection:** the sample strobe occurs FILTER_LEN+3 clk cycles after a raw ps2_clk falling edge.
- **Stop-bit path:** with the stop-bit strobe in cycle T:
  - The decoder registers its result in T+1.
  - The FIFO write occurs at the end of T+1.
  - empty=0, the updated count, and rd_data valid are visible in T+2.
- **Error pulses:**
  - frame_err is high for exactly cycle T+1.
  - overflow is high for exactly one cycle, aligned with the dropped write.
- **Pop:** rd_en in cycle P advances the head. The next rd_data, count, and empty are visible in P+1.
- **Throughput:** at most one push per frame, far below one per cycle. Pops may occur on every cycle.

## Test plan
- Frame 0x1C (parity bit 0, stop bit 1) → after the stop bit, empty=0, rd_data=0x61, count=1. rd_en for one cycle → empty=1, rd_data=0x00.
- Sequence 12, 1C, F0 1C, F0 12, 1C → FIFO holds exactly 0x41, then 0x61. Break codes push nothing.
- Frame 0x1C with parity bit 1 → frame_err pulses for one cycle and empty stays 1. A following good 0x45 frame → rd_data=0x30.
- Seventeen 0x16 frames with no pops → full=1 at count=16, overflow pulses on the 17th, count stays 16. Sixteen pops all return 0x31, then empty=1.
- Start bit plus 4 data bits, then idle for TIMEOUT+10 cycles, then a full 0x29 frame → no frame_err, rd_data=0x20, count=1.
- Assert rst_n=0 after the 6th bit of a frame while the FIFO holds 3 characters → all outputs return to reset values immediately. A fresh 0x5A frame after release → rd_data=0x0D, count=1.
